// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the requesting masters and the arbiter.
// The masters drive req/done; the arbiter answers with a registered grant.
interface bus_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic          timeout;

    modport master (output req, done, input grant, grant_idx, busy, timeout);
    modport slave  (input req, done, output grant, grant_idx, busy, timeout);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for one multi-cycle shared resource.
// Grants are registered and one-hot, held until the owner finishes, drops
// its request, or the watchdog revokes it after TIMEOUT cycles.
module bus_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          clear_n,
    bus_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_ON = (TIMEOUT != 0);
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [CW-1:0] cnt;

    logic [N-1:0]  cand;
    logic [IW-1:0] probe;
    logic [IW-1:0] winner;
    logic          found;
    logic          rel_done;
    logic          rel_abort;
    logic          rel_wd;
    logic          rel;

    // Pick the first pending requester after `last`; the current owner is
    // masked out so a release can never hand the grant straight back to it.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise synthesis infers a latch to hold the old value.
        cand   = bus.req;
        found  = 1'b0;
        winner = '0;
        probe  = '0;
        if (state == GRANTED) cand[bus.grant_idx] = 1'b0;
        // Walk from the farthest slot inward so the nearest hit is written last.
        for (int i = N; i >= 1; i--) begin
            probe = IW'((int'(last) + i) % N);
            if (cand[probe]) begin
                found  = 1'b1;
                winner = probe;
            end
        end
    end

    // Release conditions for the current owner, in priority order done > abort > watchdog.
    always_comb begin
        rel_done  = 1'b0;
        rel_abort = 1'b0;
        rel_wd    = 1'b0;
        if (state == GRANTED) begin
            rel_done  = bus.done;
            rel_abort = ~bus.req[bus.grant_idx];
            rel_wd    = WD_ON && (cnt == T_LAST);
        end
    end

    assign rel = rel_done | rel_abort | rel_wd;

    // Arbiter FSM: issues, holds and hands over grants; all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (!clear_n) begin
            state         <= IDLE;
            bus.grant     <= '0;
            bus.grant_idx <= '0;
            bus.busy      <= 1'b0;
            bus.timeout   <= 1'b0;
            last          <= IW'(N - 1);
            cnt           <= '0;
        end else begin
            bus.timeout <= 1'b0;
            if (state == IDLE || rel) begin
                // Watchdog only reports when it was the deciding release reason.
                if (state == GRANTED) bus.timeout <= rel_wd & ~rel_done & ~rel_abort;
                if (found) begin
                    state         <= GRANTED;
                    bus.grant     <= ONE << winner;
                    bus.grant_idx <= winner;
                    bus.busy      <= 1'b1;
                    last          <= winner;
                    cnt           <= '0;
                end else begin
                    state         <= IDLE;
                    bus.grant     <= '0;
                    bus.grant_idx <= '0;
                    bus.busy      <= 1'b0;
                    cnt           <= '0;
                end
            end else if (cnt != '1) begin
                // Saturating hold counter: never wraps back to zero.
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (N=4, TIMEOUT=8): directed scenarios
// with a scoreboard queue, per-cycle invariants and a random fairness run.
module tb_bus_arbiter;
    localparam int N       = 4;
    localparam int TIMEOUT = 8;
    localparam int WAIT_MAX = (N - 1) * TIMEOUT + N;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] idx;
        logic       tmo;
    } exp_t;

    logic clk = 1'b0;
    logic clear_n;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   wait_cnt[N];
    int   max_wait[N];

    bus_arbiter_if #(.N(N)) bus ();

    bus_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports a failure with tag and values.
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs after the edge, then compare.
    task automatic step(input logic c, input logic [3:0] r, input logic d,
                        input logic [3:0] g, input logic [1:0] ix, input logic t,
                        input string tag);
        exp_t e;
        exp_t want;
        clear_n  = c;
        bus.req  = r;
        bus.done = d;
        e.grant  = g;
        e.idx    = ix;
        e.tmo    = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        check({tag, ".grant"},   32'(bus.grant),     32'(want.grant));
        check({tag, ".idx"},     32'(bus.grant_idx), 32'(want.idx));
        check({tag, ".busy"},    32'(bus.busy),      32'(|want.grant));
        check({tag, ".timeout"}, 32'(bus.timeout),   32'(want.tmo));
    endtask

    // Structural invariants every cycle, plus per-requester wait tracking.
    always @(negedge clk) begin
        check("inv_onehot", 32'($onehot0(bus.grant)), 32'd1);
        check("inv_busy",   32'(bus.busy), 32'(|bus.grant));
        check("inv_idx",    32'(bus.grant[bus.grant_idx]), 32'(bus.busy));
        for (int i = 0; i < N; i++) begin
            if (clear_n && bus.req[i] && !bus.grant[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = 0;
            max_wait[i] = 0;
        end

        // Reset state.
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "reset0");
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "reset1");
        // done while idle is ignored.
        step(1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "idle_done");

        // All requesting, done on the 3rd cycle of each grant: 0,1,2,3,0 back-to-back.
        step(1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, "rr_first");
        for (int o = 0; o < 4; o++) begin
            step(1'b1, 4'b1111, 1'b0, 4'(1 << o), 2'(o), 1'b0, "rr_hold_a");
            step(1'b1, 4'b1111, 1'b0, 4'(1 << o), 2'(o), 1'b0, "rr_hold_b");
            step(1'b1, 4'b1111, 1'b1, 4'(1 << ((o + 1) % 4)), 2'((o + 1) % 4), 1'b0, "rr_handover");
        end
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "rr_abort_idle");

        // Single requester: 2-cycle grant, one idle cycle, then granted again.
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "solo_grant");
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "solo_hold");
        step(1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, "solo_gap");
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "solo_regrant");
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "solo_idle");

        // Watchdog: grant held exactly TIMEOUT cycles, then a one-cycle timeout pulse.
        step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_grant");
        for (int k = 0; k < TIMEOUT - 1; k++)
            step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_hold");
        step(1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b1, "wd_expire");
        step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "wd_regrant");

        // done coinciding with watchdog expiry counts as done: no timeout pulse.
        for (int k = 0; k < TIMEOUT - 1; k++)
            step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "wd2_hold");
        step(1'b1, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, "wd2_done");
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "wd2_idle");

        // Owner 2 aborts while requester 3 waits: immediate handover.
        step(1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "abort_grant");
        step(1'b1, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b0, "abort_hold");
        step(1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "abort_handover");
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "abort_idle");

        // Reset mid-grant, then the pointer restarts at requester 0.
        step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "clr_grant");
        step(1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "clr_hold");
        step(1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, "clr_reset");
        step(1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, "clr_ptr");
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "clr_idle");

        // Random traffic: invariants are checked every cycle by the monitor.
        clear_n = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
            bus.done = ($urandom_range(0, 9) == 0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < N; i++)
            check($sformatf("wait_bound%0d", i), 32'(max_wait[i] <= WAIT_MAX), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
